// File: rtl/down_timer_pkg.sv
// Shared definitions for the down-counting timer: state encoding and mode constants.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_timer_prescaler.sv
// Clock prescaler for the down timer: emits a tick once every pre_div_i+1 enabled cycles.
module down_timer_prescaler #(
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [PRE_WIDTH-1:0] pre_div_i,
    output logic                 tick_o
);

    logic [PRE_WIDTH-1:0] pre_cnt_q;
    logic [PRE_WIDTH-1:0] pre_cnt_d;

    assign tick_o = enable_i && (pre_cnt_q == pre_div_i);

    // Clear takes precedence so a restart always begins a full prescale period.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clear_i) begin
            pre_cnt_d = '0;
        end else if (enable_i) begin
            pre_cnt_d = tick_o ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot/periodic modes, prescaler and pause/stop.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     load_val_i,
    input  logic [PRE_WIDTH-1:0] prescale_i,
    input  logic                 periodic_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 pause_i,
    output logic [WIDTH-1:0]     cnt_out_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 expire_o
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     reload_q, reload_d;
    logic [PRE_WIDTH-1:0] pre_div_q, pre_div_d;
    logic                 mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 expire_q, expire_d;
    logic                 active;
    logic                 tick;

    // Leaving HOLD on the same edge that counts keeps each HOLD cycle worth exactly one cycle of delay.
    assign active = ((state_q == RUN) || (state_q == HOLD)) && !pause_i && !start_i && !stop_i;

    down_timer_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .enable_i  (active),
        .clear_i   (start_i || stop_i),
        .pre_div_i (pre_div_q),
        .tick_o    (tick)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        pre_div_d = pre_div_q;
        mode_d    = mode_q;
        expire_d  = 1'b0;
        if (stop_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start_i) begin
            reload_d  = load_val_i;
            pre_div_d = prescale_i;
            mode_d    = periodic_i;
            cnt_d     = load_val_i;
            if (load_val_i != '0) begin
                state_d = RUN;
            end else begin
                state_d  = DONE;
                expire_d = 1'b1;
            end
        end else if ((state_q == RUN) || (state_q == HOLD)) begin
            if (pause_i) begin
                state_d = HOLD;
            end else begin
                state_d = RUN;
                if (tick) begin
                    if (cnt_q > 1) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        expire_d = 1'b1;
                        if (mode_q == MODE_PERIODIC) begin
                            cnt_d = reload_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
        end
        busy_d = (state_d == RUN) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            reload_q  <= '0;
            pre_div_q <= '0;
            mode_q    <= MODE_ONESHOT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            pre_div_q <= pre_div_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            expire_q  <= expire_d;
        end
    end

    assign cnt_out_o = cnt_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign expire_o  = expire_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer with hand-computed expected values.
module tb_down_timer;

    logic       clk;
    logic       rst;
    logic [4:0] load_val;
    logic [3:0] prescale;
    logic       periodic;
    logic       start;
    logic       stop;
    logic       pause;
    logic [4:0] cnt_out;
    logic       busy;
    logic       done;
    logic       expire;

    int errorCount = 0;
    int checkCount = 0;

    down_timer #(
        .WIDTH     (5),
        .PRE_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_val_i (load_val),
        .prescale_i (prescale),
        .periodic_i (periodic),
        .start_i    (start),
        .stop_i     (stop),
        .pause_i    (pause),
        .cnt_out_o  (cnt_out),
        .busy_o     (busy),
        .done_o     (done),
        .expire_o   (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic [4:0] lv,
                                 input logic [3:0] ps, input logic per);
        start    = st;
        stop     = sp;
        load_val = lv;
        prescale = ps;
        periodic = per;
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [4:0] c, input logic b, input logic d, input logic e);
        checkOutput({tag, ".cnt"}, cnt_out, c);
        checkOutput({tag, ".busy"}, busy, b);
        checkOutput({tag, ".done"}, done, d);
        checkOutput({tag, ".expire"}, expire, e);
    endtask

    initial begin
        rst   = 1'b1;
        pause = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        stepClk();
        stepClk();
        rst = 1'b0;
        checkAll("reset", 5'd0, 1'b0, 1'b0, 1'b0);

        // One-shot, load 5, prescale 0
        applyStimulus(1'b1, 1'b0, 5'd5, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        checkAll("os.n0", 5'd5, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            stepClk();
            checkAll($sformatf("os.n%0d", k), 5'(5 - k), 1'b1, 1'b0, 1'b0);
        end
        stepClk();
        checkAll("os.expire", 5'd0, 1'b0, 1'b1, 1'b1);
        stepClk();
        checkAll("os.after", 5'd0, 1'b0, 1'b1, 1'b0);

        // Periodic, load 3, prescale 1: expiry every 6 cycles
        applyStimulus(1'b1, 1'b0, 5'd3, 4'd1, 1'b1);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        checkAll("per.n0", 5'd3, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            for (int k = 1; k <= 6; k++) begin
                stepClk();
                checkOutput($sformatf("per.p%0d.k%0d.expire", p, k), expire, (k == 6));
                checkOutput($sformatf("per.p%0d.k%0d.done", p, k), done, 1'b0);
                if (k == 2) checkOutput($sformatf("per.p%0d.cnt2", p), cnt_out, 5'd2);
                if (k == 4) checkOutput($sformatf("per.p%0d.cnt4", p), cnt_out, 5'd1);
                if (k == 6) checkOutput($sformatf("per.p%0d.reload", p), cnt_out, 5'd3);
            end
        end
        applyStimulus(1'b0, 1'b1, 5'd0, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        checkAll("per.stop", 5'd0, 1'b0, 1'b0, 1'b0);

        // Pause: one-shot load 4, pause 3 cycles once cnt reaches 2
        applyStimulus(1'b1, 1'b0, 5'd4, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        stepClk();
        stepClk();
        checkAll("pau.pre", 5'd2, 1'b1, 1'b0, 1'b0);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stepClk();
            checkAll($sformatf("pau.hold%0d", k), 5'd2, 1'b1, 1'b0, 1'b0);
        end
        pause = 1'b0;
        stepClk();
        checkAll("pau.resume", 5'd1, 1'b1, 1'b0, 1'b0);
        stepClk();
        checkAll("pau.expire", 5'd0, 1'b0, 1'b1, 1'b1);

        // Start with load 0: immediate DONE and expire pulse
        applyStimulus(1'b1, 1'b0, 5'd0, 4'd3, 1'b1);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        checkAll("zero.expire", 5'd0, 1'b0, 1'b1, 1'b1);
        stepClk();
        checkAll("zero.after", 5'd0, 1'b0, 1'b1, 1'b0);

        // Stop together with start while running: stop wins
        applyStimulus(1'b1, 1'b0, 5'd5, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b1, 1'b1, 5'd9, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        checkAll("stopstart", 5'd0, 1'b0, 1'b0, 1'b0);

        // Restart at the would-be expiry edge: no pulse, new count loaded
        applyStimulus(1'b1, 1'b0, 5'd2, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        stepClk();
        checkAll("restart.pre", 5'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd7, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        checkAll("restart", 5'd7, 1'b1, 1'b0, 1'b0);
        stepClk();
        checkAll("restart.n1", 5'd6, 1'b1, 1'b0, 1'b0);

        // Reset mid-run in periodic mode, then a normal one-shot
        applyStimulus(1'b1, 1'b0, 5'd5, 4'd0, 1'b1);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        stepClk();
        stepClk();
        checkAll("rstmid.pre", 5'd3, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        stepClk();
        rst = 1'b0;
        checkAll("rstmid", 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd2, 4'd0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        checkAll("post.n0", 5'd2, 1'b1, 1'b0, 1'b0);
        stepClk();
        checkAll("post.n1", 5'd1, 1'b1, 1'b0, 1'b0);
        stepClk();
        checkAll("post.expire", 5'd0, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/down_timer.md
# down_timer

Programmable down-counting timer that complements the team's up-counter: it is loaded with a terminal count and decrements toward zero instead of counting up from a load value. It produces a one-cycle expiry pulse and supports one-shot and periodic (auto-reload) modes, a clock prescaler, and pause/stop control. It sits beside the up-counter in the datapath wherever a timeout, interval tick or delay is needed.

## Interface
- WIDTH, 5, width of the count and load value
- PRE_WIDTH, 4, width of the prescale divisor
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_val  in  WIDTH  terminal count, sampled on start
- prescale  in  PRE_WIDTH  divisor minus one; one decrement every prescale+1 cycles; sampled on start
- periodic  in  1  1 = auto-reload on expiry, 0 = one-shot; sampled on start
- start  in  1  load and (re)start the timer
- stop  in  1  abort and return to IDLE
- pause  in  1  level; freezes count and prescaler while high in RUN
- cnt_out  out  WIDTH  current remaining count, registered
- busy  out  1  high in RUN or HOLD
- done  out  1  high in DONE (one-shot completed)
- expire  out  1  one-cycle pulse on every expiry

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Internal registers: reload (WIDTH), pre_div (PRE_WIDTH), mode (1), pre_cnt (PRE_WIDTH).
- Priority per edge: rst > stop > start > pause > tick.
- rst: state IDLE; cnt_out, pre_cnt, reload, pre_div, mode all 0; busy, done and expire 0.
- stop, any state: IDLE, cnt_out 0, pre_cnt 0, expire 0.
- start, any state (restart allowed):
  - Latch load_val into reload, prescale into pre_div, periodic into mode; cnt_out set to load_val; pre_cnt set to 0.
  - If load_val != 0, go to RUN.
  - If load_val == 0, go to DONE with expire 1 next cycle, regardless of periodic.
- RUN:
  - Tick when pre_cnt == pre_div: pre_cnt returns to 0; otherwise pre_cnt increments.
  - On a tick with cnt_out > 1: cnt_out decrements.
  - On a tick with cnt_out == 1: expire pulses. If mode = 1, cnt_out reloads and the state stays RUN; otherwise cnt_out goes to 0 and the state goes to DONE.
- HOLD:
  - Entered from RUN when pause = 1; cnt_out and pre_cnt are frozen.
  - Returns to RUN on the first edge where pause = 0.
  - pause in IDLE or DONE is ignored.
- DONE: holds cnt_out = 0 until start or stop.
- Arithmetic: unsigned; cnt_out never wraps below 0 (the expiry check at 1 prevents it). Maximum interval is (2^WIDTH-1)*(2^PRE_WIDTH) cycles.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Start sampled at edge N: cnt_out = load_val and busy = 1 after edge N.
- Expiry timing: expire is high for exactly the cycle following edge N + load_val*(prescale+1). In that same cycle cnt_out = 0 and done = 1 (one-shot), or cnt_out = load_val (periodic).
- Periodic mode: expire pulses every load_val*(prescale+1) cycles with no gap or extra cycle at reload.
- Pause: each cycle spent in HOLD delays expiry by exactly one cycle. The pause→HOLD transition costs no additional cycle.
- start in the same cycle as a would-be expiry: the restart wins and no expire pulse is produced.
- stop in the same cycle as start: stop wins.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3)
  - mode constants MODE_ONESHOT=1'b0 and MODE_PERIODIC=1'b1
- One natural sub-module: down_timer_prescaler.
  - Contains the pre_cnt register and the tick generator.
  - Inputs: enable, clear, pre_div.
  - Output: tick.
- The FSM and the count register remain in down_timer.

## Test plan
- rst held 2 cycles, then released: cnt_out=0, busy=0, done=0, expire=0.
- One-shot, load_val=5, prescale=0, periodic=0, start pulsed at edge N: cnt_out reads 5,4,3,2,1, then 0; expire is high one cycle after edge N+5; done=1; busy=0.
- Periodic, load_val=3, prescale=1: expire pulses every 6 cycles for at least 4 periods; cnt_out reloads to 3 at each expiry; done stays 0.
- Pause: one-shot with load_val=4, prescale=0; pause high 3 cycles starting when cnt_out=2: cnt_out frozen at 2, busy=1, and expire arrives 3 cycles later than the unpaused case.
- Control collisions:
  - start with load_val=0: DONE, expire for 1 cycle.
  - stop asserted together with start: IDLE, cnt_out=0.
  - start asserted at the expiry cycle with load_val=7: no expire, cnt_out=7.
- rst mid-run (cnt_out=3, periodic): the next cycle shows all outputs 0 and state IDLE; a subsequent start behaves normally.
